id_issue_ctrl: RTL and testbench

- Issue controller between instruction fetch and the decode/immediate-generation stage of the RV32I core.
- Owns the IF/ID pipeline register and its valid/ready handshakes.
- Detects load-use hazards against the load in EX and inserts bubbles; flushes the ID slot on taken branches/jumps.
- Counts bubble cycles for performance monitoring.

---
 rtl/id_issue_ctrl.sv | 87 ++++++++
 tb/tb_id_issue_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: IF/ID issue register with load-use stall, branch flush and bubble counting
module id_issue_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_i,
  input  logic [31:0] if_inst_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i,
  input  logic        ex_load_valid_i,
  input  logic [4:0]  ex_load_rd_i,
  input  logic        branch_taken_i,
  output logic        stall_o,
  output logic [15:0] bubble_cnt_o
);
  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic full, use_rs1, use_rs2, hazard, xfer, consume;
  logic [31:0] inst, pc;
  logic [6:0] op;
  logic [15:0] bubble_cnt;
  assign op = inst[6:0];
  assign use_rs1 = op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b1100111};
  assign use_rs2 = op inside {7'b0100011, 7'b1100011, 7'b0110011};
  assign hazard = full & ex_load_valid_i & (ex_load_rd_i != 5'd0) &
                  ((use_rs1 & (ex_load_rd_i == inst[19:15])) | (use_rs2 & (ex_load_rd_i == inst[24:20])));
  assign xfer = if_valid_i & if_ready_o;
  assign consume = id_valid_o & id_ready_i;
  assign id_inst_o = inst;
  assign id_pc_o = pc;
  assign bubble_cnt_o = bubble_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt - 2'd1;
    if (branch_taken_i) begin
      state_nxt = FLUSH;
      cnt_nxt = 2'(FLUSH_CYC - 1);
    end else if (state == RUN) begin
      state_nxt = hazard ? LDSTALL : RUN;
      cnt_nxt = 2'(LOAD_LAT - 1);
    end else if (cnt == 2'd0) begin
      state_nxt = RUN;
      cnt_nxt = 2'd0;
    end
  end
  always_comb begin
    id_valid_o = (state == RUN) & full & !hazard;
    if_ready_o = rst_n & (state == RUN) & (!full | id_ready_i) & !hazard & !branch_taken_i;
    stall_o = state == LDSTALL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      inst <= NOP_INST;
      pc <= 32'h0;
      bubble_cnt <= 16'h0;
    end else begin
      if (branch_taken_i) begin
        full <= 1'b0;
        inst <= NOP_INST;
      end else if (xfer) begin
        full <= 1'b1;
        inst <= if_inst_i;
        pc <= if_pc_i;
      end else if (consume) begin
        full <= 1'b0;
        inst <= NOP_INST;
      end
      if (((state != RUN) | hazard) & (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
    end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: scoreboard bench for id_issue_ctrl with LOAD_LAT=1, FLUSH_CYC=2
module tb_id_issue_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid_i = 1'b0, id_ready_i = 1'b1, ex_load_valid_i = 1'b0, branch_taken_i = 1'b0;
  logic [31:0] if_inst_i = 32'h0, if_pc_i = 32'h0;
  logic [4:0] ex_load_rd_i = 5'd0;
  logic if_ready_o, id_valid_o, stall_o;
  logic [31:0] id_inst_o, id_pc_o;
  logic [15:0] bubble_cnt_o;
  logic [63:0] sb[$];
  logic [63:0] sb_e;
  logic [15:0] exp_bub = 16'h0;
  int n_chk = 0, n_fail = 0, n_pop = 0;
  always #5 clk = ~clk;
  id_issue_ctrl #(.LOAD_LAT(1), .FLUSH_CYC(2), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
    .if_ready_o(if_ready_o), .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .id_ready_i(id_ready_i), .ex_load_valid_i(ex_load_valid_i), .ex_load_rd_i(ex_load_rd_i),
    .branch_taken_i(branch_taken_i), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );
  task automatic half();
    @(negedge clk);
    if (rst_n) begin
      if (id_valid_o && id_ready_i) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL sb_issue: got %h@%h, none expected", id_inst_o, id_pc_o); end
        else begin
          sb_e = sb.pop_front();
          n_pop++;
          if ({id_inst_o, id_pc_o} !== sb_e) begin n_fail++; $display("FAIL sb_issue: got %h@%h want %h@%h", id_inst_o, id_pc_o, sb_e[63:32], sb_e[31:0]); end
        end
      end
      if (branch_taken_i) sb.delete();
      if (if_valid_i && if_ready_o) sb.push_back({if_inst_i, if_pc_i});
    end
  endtask
  task automatic fin();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; if_valid_i = 1'b1; if_inst_i = 32'hdeadbeef; if_pc_i = 32'h44;
    fin(); half();
    n_chk++; if ({if_ready_o, id_valid_o, stall_o} !== 3'b000) begin n_fail++; $display("FAIL rst_hs: got %b want 000", {if_ready_o, id_valid_o, stall_o}); end
    n_chk++; if ({id_inst_o, id_pc_o, bubble_cnt_o} !== {NOP, 32'h0, 16'h0}) begin n_fail++; $display("FAIL rst_val: got %h %h %h", id_inst_o, id_pc_o, bubble_cnt_o); end
    fin(); rst_n = 1'b1;
    half(); fin();
    if_valid_i = 1'b0; id_ready_i = 1'b0;
    half();
    n_chk++; if ({id_valid_o, id_inst_o, id_pc_o} !== {1'b1, 32'hdeadbeef, 32'h44}) begin n_fail++; $display("FAIL pre_rst: got %b %h %h", id_valid_o, id_inst_o, id_pc_o); end
    rst_n = 1'b0; sb.delete(); #1;
    n_chk++; if ({id_valid_o, if_ready_o, id_inst_o, id_pc_o, bubble_cnt_o} !== {2'b00, NOP, 32'h0, 16'h0}) begin n_fail++; $display("FAIL async_rst: got %b%b %h %h %h", id_valid_o, if_ready_o, id_inst_o, id_pc_o, bubble_cnt_o); end
    fin(); rst_n = 1'b1; if_valid_i = 1'b1; if_inst_i = 32'h00500093; if_pc_i = 32'h0; id_ready_i = 1'b1;
    half();
    n_chk++; if ({id_valid_o, if_ready_o, id_inst_o} !== {2'b01, NOP}) begin n_fail++; $display("FAIL post_rst: got %b%b %h", id_valid_o, if_ready_o, id_inst_o); end
    fin(); if_valid_i = 1'b0;
    half();
    n_chk++; if ({id_valid_o, id_inst_o, id_pc_o} !== {1'b1, 32'h00500093, 32'h0}) begin n_fail++; $display("FAIL first_fetch: got %b %h %h", id_valid_o, id_inst_o, id_pc_o); end
    fin();
  endtask
  task automatic test_load_use();
    if_valid_i = 1'b1; if_inst_i = 32'h00728333; if_pc_i = 32'h200; id_ready_i = 1'b1;
    half(); fin();
    if_valid_i = 1'b0; ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd5;
    half();
    n_chk++; if ({id_valid_o, stall_o, if_ready_o, bubble_cnt_o} !== {3'b000, exp_bub}) begin n_fail++; $display("FAIL lu_hazard: got %b%b%b %h want 000 %h", id_valid_o, stall_o, if_ready_o, bubble_cnt_o, exp_bub); end
    fin(); ex_load_valid_i = 1'b0; exp_bub++;
    half();
    n_chk++; if ({id_valid_o, stall_o, id_inst_o, bubble_cnt_o} !== {2'b01, 32'h00728333, exp_bub}) begin n_fail++; $display("FAIL lu_stall: got %b%b %h %h want 01 00728333 %h", id_valid_o, stall_o, id_inst_o, bubble_cnt_o, exp_bub); end
    fin(); exp_bub++;
    half();
    n_chk++; if ({id_valid_o, stall_o, bubble_cnt_o} !== {2'b10, exp_bub}) begin n_fail++; $display("FAIL lu_issue: got %b%b %h want 10 %h", id_valid_o, stall_o, bubble_cnt_o, exp_bub); end
    fin();
    for (int i = 0; i < 2; i++) begin
      if_valid_i = 1'b1; if_inst_i = i ? 32'h000282b7 : 32'h00728333; if_pc_i = 32'h204 + 32'(4 * i); ex_load_valid_i = 1'b0;
      half(); fin();
      if_valid_i = 1'b0; ex_load_valid_i = 1'b1; ex_load_rd_i = i ? 5'd5 : 5'd0;
      half();
      n_chk++; if ({id_valid_o, stall_o, if_ready_o} !== 3'b101) begin n_fail++; $display("FAIL lu_nohaz%0d: got %b%b%b want 101", i, id_valid_o, stall_o, if_ready_o); end
      fin();
    end
    if_valid_i = 1'b1; if_inst_i = 32'h00728333; if_pc_i = 32'h20c; ex_load_valid_i = 1'b0;
    half(); fin();
    if_valid_i = 1'b0; ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd7;
    half();
    n_chk++; if ({id_valid_o, if_ready_o} !== 2'b00) begin n_fail++; $display("FAIL lu_rs2: got %b%b want 00", id_valid_o, if_ready_o); end
    fin(); ex_load_valid_i = 1'b0; exp_bub++;
    half(); fin(); exp_bub++;
    half();
    n_chk++; if ({id_valid_o, bubble_cnt_o} !== {1'b1, exp_bub}) begin n_fail++; $display("FAIL lu_rs2_issue: got %b %h want 1 %h", id_valid_o, bubble_cnt_o, exp_bub); end
    fin();
  endtask
  task automatic test_back_pressure();
    logic [31:0] w [8];
    int k, c, p0;
    logic acc;
    k = 0; c = 0; p0 = n_pop;
    for (int i = 0; i < 8; i++) w[i] = 32'h00000033 | (32'(i) << 7);
    while ((k < 8 || sb.size() != 0) && c < 40) begin
      if_valid_i = k < 8; if_inst_i = w[k & 7]; if_pc_i = 32'h600 + 32'(4 * k);
      id_ready_i = !(c >= 2 && c <= 4);
      half();
      if (!id_ready_i) begin
        n_chk++; if ({if_ready_o, id_inst_o} !== {1'b0, w[1]}) begin n_fail++; $display("FAIL bp_hold: got %b %h want 0 %h", if_ready_o, id_inst_o, w[1]); end
      end
      acc = if_valid_i && if_ready_o;
      fin();
      if (acc) k++;
      c++;
    end
    if_valid_i = 1'b0; id_ready_i = 1'b1;
    n_chk++; if ({k, n_pop - p0} !== {32'd8, 32'd8}) begin n_fail++; $display("FAIL bp_count: accepted %0d issued %0d want 8 8", k, n_pop - p0); end
  endtask
  task automatic test_branch_flush();
    if_valid_i = 1'b1; if_inst_i = 32'h00728333; if_pc_i = 32'h300; id_ready_i = 1'b0;
    half(); fin();
    branch_taken_i = 1'b1; if_inst_i = 32'h00a00113; if_pc_i = 32'h400;
    half();
    n_chk++; if ({if_ready_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL br_pulse: got %b%b want 00", if_ready_o, stall_o); end
    fin(); branch_taken_i = 1'b0; id_ready_i = 1'b1;
    half();
    n_chk++; if ({if_ready_o, id_valid_o, id_inst_o, id_pc_o, bubble_cnt_o} !== {2'b00, NOP, 32'h300, exp_bub}) begin n_fail++; $display("FAIL br_flush1: got %b%b %h %h %h", if_ready_o, id_valid_o, id_inst_o, id_pc_o, bubble_cnt_o); end
    fin(); exp_bub++;
    half();
    n_chk++; if ({if_ready_o, id_valid_o, bubble_cnt_o} !== {2'b00, exp_bub}) begin n_fail++; $display("FAIL br_flush2: got %b%b %h want 00 %h", if_ready_o, id_valid_o, bubble_cnt_o, exp_bub); end
    fin(); exp_bub++;
    half();
    n_chk++; if ({if_ready_o, id_valid_o, stall_o, bubble_cnt_o} !== {3'b100, exp_bub}) begin n_fail++; $display("FAIL br_run: got %b%b%b %h want 100 %h", if_ready_o, id_valid_o, stall_o, bubble_cnt_o, exp_bub); end
    fin(); if_valid_i = 1'b0;
    half();
    n_chk++; if ({id_valid_o, id_inst_o, id_pc_o} !== {1'b1, 32'h00a00113, 32'h400}) begin n_fail++; $display("FAIL br_next: got %b %h %h", id_valid_o, id_inst_o, id_pc_o); end
    fin();
  endtask
  task automatic test_simultaneous();
    if_valid_i = 1'b1; if_inst_i = 32'h00728333; if_pc_i = 32'h500; id_ready_i = 1'b1;
    half(); fin();
    if_valid_i = 1'b0; ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd5;
    half();
    n_chk++; if ({id_valid_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL sim_hazard: got %b%b want 00", id_valid_o, stall_o); end
    fin(); ex_load_valid_i = 1'b0; branch_taken_i = 1'b1; exp_bub++;
    half();
    n_chk++; if ({stall_o, id_valid_o, if_ready_o, bubble_cnt_o} !== {3'b100, exp_bub}) begin n_fail++; $display("FAIL sim_last_stall: got %b%b%b %h want 100 %h", stall_o, id_valid_o, if_ready_o, bubble_cnt_o, exp_bub); end
    fin(); branch_taken_i = 1'b0; exp_bub++; if_valid_i = 1'b1; if_inst_i = 32'h00b00193; if_pc_i = 32'h600;
    half();
    n_chk++; if ({stall_o, id_valid_o, if_ready_o, id_inst_o, id_pc_o} !== {3'b000, NOP, 32'h500}) begin n_fail++; $display("FAIL sim_flush: got %b%b%b %h %h", stall_o, id_valid_o, if_ready_o, id_inst_o, id_pc_o); end
    fin(); exp_bub++;
    half();
    n_chk++; if ({if_ready_o, bubble_cnt_o} !== {1'b0, exp_bub}) begin n_fail++; $display("FAIL sim_flush2: got %b %h want 0 %h", if_ready_o, bubble_cnt_o, exp_bub); end
    fin(); exp_bub++;
    half();
    n_chk++; if ({if_ready_o, bubble_cnt_o} !== {1'b1, exp_bub}) begin n_fail++; $display("FAIL sim_run: got %b %h want 1 %h", if_ready_o, bubble_cnt_o, exp_bub); end
    fin(); if_valid_i = 1'b0;
    half();
    n_chk++; if ({id_valid_o, id_inst_o} !== {1'b1, 32'h00b00193}) begin n_fail++; $display("FAIL sim_issue: got %b %h", id_valid_o, id_inst_o); end
    fin();
  endtask
  task automatic test_saturation();
    int n;
    n = 'hFFFD - int'(exp_bub);
    branch_taken_i = 1'b1;
    repeat (n) begin half(); fin(); end
    branch_taken_i = 1'b0;
    repeat (2) begin half(); fin(); end
    half();
    n_chk++; if ({bubble_cnt_o, if_ready_o} !== {16'hFFFE, 1'b1}) begin n_fail++; $display("FAIL sat_fffe: got %h %b want fffe 1", bubble_cnt_o, if_ready_o); end
    for (int p = 0; p < 2; p++) begin
      fin(); branch_taken_i = 1'b1;
      half(); fin(); branch_taken_i = 1'b0;
      half(); fin();
      half();
      n_chk++; if (bubble_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_a%0d: got %h want ffff", p, bubble_cnt_o); end
      fin();
      half();
      n_chk++; if (bubble_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_b%0d: got %h want ffff", p, bubble_cnt_o); end
    end
    fin();
  endtask
  task automatic test_reset_mid_stall();
    if_valid_i = 1'b1; if_inst_i = 32'h00728333; if_pc_i = 32'h700; id_ready_i = 1'b1;
    half(); fin();
    if_valid_i = 1'b0; ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd5;
    half(); fin();
    ex_load_valid_i = 1'b0;
    half();
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rms_stall: got %b want 1", stall_o); end
    rst_n = 1'b0; sb.delete(); #1;
    n_chk++; if ({stall_o, id_valid_o, if_ready_o, id_inst_o, bubble_cnt_o} !== {3'b000, NOP, 16'h0}) begin n_fail++; $display("FAIL rms_reset: got %b%b%b %h %h", stall_o, id_valid_o, if_ready_o, id_inst_o, bubble_cnt_o); end
    fin(); rst_n = 1'b1;
    half();
    n_chk++; if ({stall_o, id_valid_o, if_ready_o, bubble_cnt_o} !== {3'b001, 16'h0}) begin n_fail++; $display("FAIL rms_after: got %b%b%b %h want 001 0000", stall_o, id_valid_o, if_ready_o, bubble_cnt_o); end
    fin();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_back_pressure();
    test_branch_flush();
    test_simultaneous();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_chk);
    $fatal(1, "timeout");
  end
endmodule
